// File: rtl/render_ctrl_mc.sv
// Render-frame controller: Avalon-MM register file plus the frame sequencer
// that fetches the lookat block, kicks the matrix unit, hands horizontal
// strips to free render cores and waits for them to drain.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE     0  | waiting for a start write
// READ_LOOKAT | lookat fetch in flight, waiting for rm_done
// CALC_MATRIX | matrix unit running, waiting for calc_done
// DISPATCH 3  | one strip per cycle to the lowest free core until HEIGHT covered
// DRAIN    4  | all strips issued, waiting for the busy mask to empty
// DONE     5  | bump FRAME_COUNT, raise done, restart if continuous
module render_ctrl_mc #(
  parameter int NUM_CORES = 4,
  parameter int COORD_W   = 16,
  parameter int ADDR_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 chipselect,
  input  logic                 read,
  input  logic                 write,
  input  logic [ADDR_W-1:0]    address,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  output logic                 interrupt,
  output logic                 rm_start,
  output logic [31:0]          rm_addr,
  output logic [31:0]          rm_len,
  input  logic                 rm_done,
  output logic                 calc_start,
  input  logic                 calc_done,
  output logic [NUM_CORES-1:0] core_start,
  output logic [COORD_W-1:0]   core_y0,
  output logic [COORD_W-1:0]   core_rows,
  input  logic [NUM_CORES-1:0] core_done,
  output logic [COORD_W-1:0]   frame_width,
  output logic [31:0]          frame_addr
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ     = 3'd1,
    S_CALC     = 3'd2,
    S_DISPATCH = 3'd3,
    S_DRAIN    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] A_CONTROL = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_IRQ     = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_WIDTH   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_HEIGHT  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_STRIP   = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_LOOKAT  = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] A_FRAME   = ADDR_W'(7);
  localparam logic [ADDR_W-1:0] A_TIMEOUT = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] A_FCOUNT  = ADDR_W'(9);

  // host-visible registers
  logic                 cont_q, en_done_q, en_to_q;
  logic                 irq_done_q, irq_to_q, irq_q;
  logic [COORD_W-1:0]   width_q, height_q, strip_q;
  logic [31:0]          lookat_q, faddr_q, timeout_q, fcount_q, rdata_q;

  // frame sequencer
  state_t               state_q;
  logic [COORD_W-1:0]   w_width_q, w_height_q, w_strip_q;
  logic [COORD_W:0]     strip_y_q;
  logic [NUM_CORES-1:0] busy_q;
  logic [31:0]          wd_q;
  logic                 rm_start_q, calc_start_q;

  logic                 wr_en, rd_en, ctrl_wr, irq_wr;
  logic                 start_req, abort_req, wd_run, wd_fire, abort_any, frame_go;
  logic                 set_done, en_done_d, en_to_d, irq_done_d, irq_to_d;
  logic [31:0]          wd_inc, fcount_d, rd_mux;
  logic [NUM_CORES-1:0] free;
  logic                 disp_ok, strips_left;
  logic [COORD_W-1:0]   rows_left;

  assign wr_en     = chipselect & write;
  assign rd_en     = chipselect & read;
  assign ctrl_wr   = wr_en && (address == A_CONTROL);
  assign irq_wr    = wr_en && (address == A_IRQ);
  assign start_req = ctrl_wr & writedata[0];
  assign abort_req = ctrl_wr & writedata[1];

  // watchdog fires on the TIMEOUT-th busy cycle, so a frame stays busy for exactly TIMEOUT cycles
  assign wd_run    = state_q inside {S_READ, S_CALC, S_DISPATCH, S_DRAIN};
  assign wd_inc    = wd_q + 32'd1;
  assign wd_fire   = wd_run && (timeout_q != 32'd0) && (wd_inc == timeout_q);
  assign abort_any = abort_req | wd_fire;

  assign frame_go  = !abort_any && (((state_q == S_IDLE) && start_req) ||
                                    ((state_q == S_DONE) && cont_q));
  assign set_done  = (state_q == S_DONE) && !abort_any;

  assign strips_left = strip_y_q < {1'b0, w_height_q};
  assign rows_left   = w_height_q - strip_y_q[COORD_W-1:0];
  assign free        = ~busy_q & ~core_done;

  // pick the lowest free core; a core finishing this cycle is not reused until the next
  always_comb begin
    core_start = '0;
    core_y0    = '0;
    core_rows  = '0;
    disp_ok    = 1'b0;
    if ((state_q == S_DISPATCH) && !abort_any && strips_left) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (free[i] && !disp_ok) begin
          core_start[i] = 1'b1;
          disp_ok       = 1'b1;
        end
      end
      if (disp_ok) begin
        core_y0   = strip_y_q[COORD_W-1:0];
        core_rows = (rows_left < w_strip_q) ? rows_left : w_strip_q;
      end
    end
  end

  // next values of enables and sticky flags; hardware set beats a W1C clear
  always_comb begin
    en_done_d  = ctrl_wr ? writedata[3] : en_done_q;
    en_to_d    = ctrl_wr ? writedata[4] : en_to_q;
    irq_done_d = set_done | (irq_done_q & ~(irq_wr & writedata[0]));
    irq_to_d   = wd_fire  | (irq_to_q   & ~(irq_wr & writedata[1]));
    fcount_d   = ((wr_en && (address == A_FCOUNT)) ? 32'd0 : fcount_q) + {31'd0, set_done};
  end

  // read mux; unmapped addresses read as zero
  always_comb begin
    rd_mux = '0;
    case (address)
      A_CONTROL: rd_mux[4:2] = {en_to_q, en_done_q, cont_q};
      A_STATUS: begin
        rd_mux[0]              = (state_q != S_IDLE);
        rd_mux[3:1]            = state_q;
        rd_mux[8 +: NUM_CORES] = busy_q;
      end
      A_IRQ:     rd_mux[1:0] = {irq_to_q, irq_done_q};
      A_WIDTH:   rd_mux = 32'(width_q);
      A_HEIGHT:  rd_mux = 32'(height_q);
      A_STRIP:   rd_mux = 32'(strip_q);
      A_LOOKAT:  rd_mux = lookat_q;
      A_FRAME:   rd_mux = faddr_q;
      A_TIMEOUT: rd_mux = timeout_q;
      A_FCOUNT:  rd_mux = fcount_q;
      default:   rd_mux = '0;
    endcase
  end

  // register file, flags, interrupt line and read data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cont_q     <= 1'b0;
      en_done_q  <= 1'b0;
      en_to_q    <= 1'b0;
      irq_done_q <= 1'b0;
      irq_to_q   <= 1'b0;
      irq_q      <= 1'b0;
      width_q    <= COORD_W'(800);
      height_q   <= COORD_W'(600);
      strip_q    <= COORD_W'(16);
      lookat_q   <= '0;
      faddr_q    <= '0;
      timeout_q  <= '0;
      fcount_q   <= '0;
      rdata_q    <= '0;
    end else begin
      en_done_q  <= en_done_d;
      en_to_q    <= en_to_d;
      irq_done_q <= irq_done_d;
      irq_to_q   <= irq_to_d;
      irq_q      <= (irq_done_d & en_done_d) | (irq_to_d & en_to_d);
      fcount_q   <= fcount_d;
      rdata_q    <= rd_en ? rd_mux : 32'd0;
      if (wr_en) begin
        case (address)
          A_CONTROL: cont_q    <= writedata[2];
          A_WIDTH:   width_q   <= writedata[COORD_W-1:0];
          A_HEIGHT:  height_q  <= writedata[COORD_W-1:0];
          A_STRIP:   strip_q   <= writedata[COORD_W-1:0];
          A_LOOKAT:  lookat_q  <= writedata;
          A_FRAME:   faddr_q   <= writedata;
          A_TIMEOUT: timeout_q <= writedata;
          default:   ;
        endcase
      end
    end
  end

  // frame sequencer with registered start pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      w_width_q    <= COORD_W'(800);
      w_height_q   <= COORD_W'(600);
      w_strip_q    <= COORD_W'(16);
      strip_y_q    <= '0;
      busy_q       <= '0;
      wd_q         <= '0;
      rm_start_q   <= 1'b0;
      calc_start_q <= 1'b0;
    end else begin
      rm_start_q   <= 1'b0;
      calc_start_q <= 1'b0;
      busy_q       <= (busy_q & ~core_done) | core_start;
      if (frame_go) begin
        wd_q       <= '0;
        strip_y_q  <= '0;
        w_width_q  <= width_q;
        w_height_q <= height_q;
        w_strip_q  <= (strip_q == '0) ? COORD_W'(1) : strip_q;
      end else if (wd_run) begin
        wd_q <= wd_inc;
      end
      if (abort_any) begin
        state_q   <= S_IDLE;
        busy_q    <= '0;
        strip_y_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: if (start_req) begin
            state_q    <= S_READ;
            rm_start_q <= 1'b1;
          end
          S_READ: if (rm_done) begin
            state_q      <= S_CALC;
            calc_start_q <= 1'b1;
          end
          S_CALC: if (calc_done) state_q <= S_DISPATCH;
          S_DISPATCH: begin
            if (!strips_left) state_q <= S_DRAIN;
            else if (disp_ok) strip_y_q <= strip_y_q + {1'b0, w_strip_q};
          end
          S_DRAIN: if (busy_q == '0) state_q <= S_DONE;
          S_DONE: begin
            if (cont_q) begin
              state_q    <= S_READ;
              rm_start_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign readdata    = rdata_q;
  assign interrupt   = irq_q;
  assign rm_start    = rm_start_q;
  assign calc_start  = calc_start_q;
  assign rm_addr     = lookat_q;
  assign rm_len      = 32'd48;
  assign frame_width = w_width_q;
  assign frame_addr  = faddr_q;

endmodule

// File: tb/tb_render_ctrl_mc.sv
// Directed bench for render_ctrl_mc: bus-driven frames against simple
// lookat/matrix responders and a pool of fixed-latency core models.
`timescale 1ns/1ps
module tb_render_ctrl_mc;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          chipselect = 1'b0, read = 1'b0, write = 1'b0;
  logic [3:0]    address = '0;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata, rm_addr, rm_len, frame_addr;
  logic          interrupt, rm_start, calc_start;
  logic          rm_done = 1'b0, calc_done = 1'b0;
  logic [NC-1:0] core_start;
  logic [NC-1:0] core_done = '0;
  logic [15:0]   core_y0, core_rows, frame_width;

  render_ctrl_mc #(.NUM_CORES(NC), .COORD_W(16), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .chipselect(chipselect), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata), .interrupt(interrupt),
    .rm_start(rm_start), .rm_addr(rm_addr), .rm_len(rm_len), .rm_done(rm_done),
    .calc_start(calc_start), .calc_done(calc_done), .core_start(core_start),
    .core_y0(core_y0), .core_rows(core_rows), .core_done(core_done),
    .frame_width(frame_width), .frame_addr(frame_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // main-owned knobs
  int   core_lat = 8;
  int   exp_h = 600, exp_s = 16;
  int   flush_req = 0;
  logic calc_en = 1'b1;

  // core pool model and strip scoreboard
  int core_cnt [NC] = '{default: 0};
  int disp_cnt = 0, exp_y = 0, last_done_cyc = 0, flush_seen = 0;
  int first_idx [4] = '{default: -1};

  always begin
    @(posedge clk); #2;
    if (flush_req != flush_seen) begin
      flush_seen = flush_req;
      exp_y = 0;
      for (int i = 0; i < NC; i++) core_cnt[i] = 0;
    end
    for (int i = 0; i < NC; i++) begin
      core_done[i] = (core_cnt[i] == 1);
      if (core_cnt[i] == 1) last_done_cyc = cyc;
      if (core_cnt[i] > 0) core_cnt[i]--;
    end
    @(negedge clk);
    if (core_start != '0) begin
      check_eq("core_start_onehot", 32'($onehot(core_start)), 32'd1);
      for (int i = 0; i < NC; i++) begin
        if (core_start[i]) begin
          if (disp_cnt < 4) first_idx[disp_cnt] = i;
          core_cnt[i] = core_lat;
        end
      end
      check_eq("core_y0", 32'(core_y0), exp_y);
      check_eq("core_rows", 32'(core_rows), ((exp_h - exp_y) < exp_s) ? (exp_h - exp_y) : exp_s);
      exp_y = exp_y + exp_s;
      if (exp_y >= exp_h) exp_y = 0;
      disp_cnt++;
    end
  end

  // lookat / matrix responders
  int rm_cnt = 0, calc_cnt = 0, rm_pulses = 0, calc_cyc = 0;
  always begin
    @(posedge clk); #2;
    rm_done = (rm_cnt == 1);
    if (rm_cnt > 0) rm_cnt--;
    calc_done = calc_en && (calc_cnt == 1);
    if (calc_done) calc_cyc = cyc;
    if (calc_cnt > 0) calc_cnt--;
    @(negedge clk);
    if (rm_start) begin
      rm_cnt = 3;
      rm_pulses++;
    end
    if (calc_start) calc_cnt = 4;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; read = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0; writedata = '0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
    tick();
    d = readdata;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    check_eq(tag, d, exp);
  endtask

  // polls STATUS every cycle; seen_cyc is the cycle the state first matched
  int   seen_cyc = 0;
  logic irq_prev = 1'b0;
  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    logic [31:0] d;
    bit hit;
    hit = 1'b0;
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = 4'h1;
    for (int k = 0; k < budget && !hit; k++) begin
      irq_prev = interrupt;
      tick();
      d = readdata;
      if (d[3:1] == st) begin
        hit = 1'b1;
        seen_cyc = cyc - 1;
      end
    end
    chipselect = 1'b0; read = 1'b0;
    check_eq({tag, "_reached"}, 32'(hit), 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int d0, p0, t0;

    // reset values
    rst_n = 1'b0;
    repeat (3) tick();
    check_eq("rst_rm_len", rm_len, 32'd48);
    check_eq("rst_frame_width", 32'(frame_width), 32'd800);
    check_eq("rst_outputs", {26'd0, interrupt, rm_start, calc_start, |core_start, |core_y0, |core_rows}, 32'd0);
    check_eq("rst_readdata", readdata, 32'd0);
    rst_n = 1'b1;
    tick();
    rd_check("rst_width", 4'h3, 32'd800);
    rd_check("rst_height", 4'h4, 32'd600);
    rd_check("rst_strip", 4'h5, 32'd16);
    rd_check("rst_status", 4'h1, 32'd0);
    rd_check("rst_fcount", 4'h9, 32'd0);
    bus_wr(4'hC, 32'hDEAD_BEEF);
    rd_check("unmapped_rd", 4'hC, 32'd0);

    // default frame: 38 strips over 4 cores
    d0 = disp_cnt;
    bus_wr(4'h0, 32'h9);
    check_eq("rm_start_rise", 32'(rm_start), 32'd1);
    tick();
    check_eq("rm_start_fall", 32'(rm_start), 32'd0);
    wait_state(3'd5, 1000, "frame_done");
    check_eq("dispatch_count", disp_cnt - d0, 32'd38);
    for (int i = 0; i < 4; i++) check_eq("first_cores", first_idx[i], i);
    check_eq("done_latency", seen_cyc, last_done_cyc + 2);
    check_eq("irq_before", 32'(irq_prev), 32'd0);
    check_eq("irq_rise", 32'(interrupt), 32'd1);
    rd_check("fcount_1", 4'h9, 32'd1);
    rd_check("irq_status_done", 4'h2, 32'd1);
    rd_check("status_idle", 4'h1, 32'd0);
    bus_wr(4'h2, 32'h1);
    check_eq("irq_w1c", 32'(interrupt), 32'd0);
    rd_check("irq_status_clr", 4'h2, 32'd0);

    // HEIGHT = 0: no strips, DONE three cycles after calc_done
    bus_wr(4'h4, 32'd0);
    exp_h = 0;
    d0 = disp_cnt;
    bus_wr(4'h0, 32'h1);
    wait_state(3'd5, 200, "h0_done");
    check_eq("h0_dispatch", disp_cnt - d0, 32'd0);
    check_eq("h0_latency", seen_cyc, calc_cyc + 3);
    rd_check("fcount_2", 4'h9, 32'd2);

    // STRIP_ROWS = 0 behaves as 1
    bus_wr(4'h4, 32'd3);
    bus_wr(4'h5, 32'd0);
    exp_h = 3; exp_s = 1;
    d0 = disp_cnt;
    bus_wr(4'h0, 32'h1);
    wait_state(3'd5, 200, "s0_done");
    check_eq("s0_dispatch", disp_cnt - d0, 32'd3);

    // continuous mode: 3 frames seen, continuous cleared during the 4th
    bus_wr(4'h4, 32'd40);
    bus_wr(4'h5, 32'd16);
    exp_h = 40; exp_s = 16;
    bus_wr(4'h9, 32'd0);
    bus_wr(4'h2, 32'h3);
    p0 = rm_pulses;
    bus_wr(4'h0, 32'hD);
    for (int f = 0; f < 3; f++) begin
      wait_state(3'd5, 300, "cont_done");
      wait_state(3'd1, 20, "cont_restart");
    end
    bus_wr(4'h0, 32'h8);
    wait_state(3'd0, 300, "cont_idle");
    rd_check("cont_fcount", 4'h9, 32'd4);
    check_eq("cont_rm_pulses", rm_pulses - p0, 32'd4);
    rd_check("cont_status", 4'h1, 32'd0);
    bus_wr(4'h2, 32'h3);
    bus_wr(4'h0, 32'h0);

    // abort during DRAIN with two cores busy
    bus_wr(4'h9, 32'd0);
    bus_wr(4'h4, 32'd32);
    exp_h = 32;
    core_lat = 30;
    bus_wr(4'h0, 32'h1);
    wait_state(3'd4, 200, "abort_drain");
    rd_check("drain_status", 4'h1, 32'h0000_0309);
    bus_wr(4'h0, 32'h2);
    rd_check("abort_status", 4'h1, 32'd0);
    repeat (35) tick();
    rd_check("abort_late_done", 4'h1, 32'd0);
    rd_check("abort_irq", 4'h2, 32'd0);
    rd_check("abort_fcount", 4'h9, 32'd0);
    core_lat = 8;
    flush_req++;

    // watchdog: matrix unit never answers
    bus_wr(4'h8, 32'd100);
    calc_en = 1'b0;
    t0 = cyc;
    bus_wr(4'h0, 32'h1);
    wait_state(3'd0, 300, "wd_idle");
    check_eq("wd_latency", seen_cyc, t0 + 101);
    rd_check("wd_irq_status", 4'h2, 32'd2);
    check_eq("wd_irq_masked", 32'(interrupt), 32'd0);
    bus_wr(4'h0, 32'h10);
    check_eq("wd_irq_enabled", 32'(interrupt), 32'd1);
    bus_wr(4'h2, 32'h2);
    check_eq("wd_irq_cleared", 32'(interrupt), 32'd0);
    bus_wr(4'h8, 32'd0);
    bus_wr(4'h0, 32'h0);
    calc_en = 1'b1;

    // reset mid-DISPATCH
    bus_wr(4'h3, 32'd640);
    bus_wr(4'h4, 32'd600);
    bus_wr(4'h6, 32'hABCD_0000);
    bus_wr(4'h7, 32'h1234_5678);
    exp_h = 600;
    bus_wr(4'h0, 32'h1);
    wait_state(3'd3, 200, "rst_dispatch");
    check_eq("live_width", 32'(frame_width), 32'd640);
    check_eq("live_rm_addr", rm_addr, 32'hABCD_0000);
    check_eq("live_frame_addr", frame_addr, 32'h1234_5678);
    rst_n = 1'b0;
    tick();
    check_eq("mid_rst_outputs", {26'd0, interrupt, rm_start, calc_start, |core_start, |core_y0, |core_rows}, 32'd0);
    check_eq("mid_rst_readdata", readdata, 32'd0);
    check_eq("mid_rst_rm_addr", rm_addr, 32'd0);
    check_eq("mid_rst_frame_addr", frame_addr, 32'd0);
    check_eq("mid_rst_width", 32'(frame_width), 32'd800);
    check_eq("mid_rst_rm_len", rm_len, 32'd48);
    rst_n = 1'b1;
    flush_req++;
    tick();
    rd_check("post_rst_width", 4'h3, 32'd800);
    rd_check("post_rst_height", 4'h4, 32'd600);
    rd_check("post_rst_lookat", 4'h6, 32'd0);
    rd_check("post_rst_status", 4'h1, 32'd0);
    rd_check("post_rst_control", 4'h0, 32'd0);
    rd_check("post_rst_fcount", 4'h9, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
